// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared field positions, flit layout and state encoding for the NoC transmitter
package noc_pkg;

   localparam int PAR_BIT     = 13;
   localparam int DST_MSB     = 12;
   localparam int DST_LSB     = 11;
   localparam int TYPE_MSB    = 10;
   localparam int TYPE_LSB    = 9;
   localparam int PAYLOAD_MSB = 8;
   localparam int PAYLOAD_LSB = 1;
   localparam int EOP_BIT     = 0;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      RESP = 2'd1,
      DATA = 2'd2,
      CTRL = 2'd3
   } noc_pkt_type_e;

   typedef struct packed {
      logic          par;
      logic [1:0]    dst;
      noc_pkt_type_e ptype;
      logic [7:0]    payload;
      logic          eop;
   } noc_flit_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } tx_state_e;

   // Parity bit that makes the whole 14-bit flit even.
   function automatic logic flit_parity(input logic [PAR_BIT-1:0] body);
      return ^body;
   endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// rtl/noc_sync_fifo.sv - synchronous FIFO with wrap-bit pointers and occupancy count
module noc_sync_fifo #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // The extra pointer bit separates the full and empty cases when addresses match.
   assign count = wr_ptr_q - rd_ptr_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rdata = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/noc_packet_tx.sv
// rtl/noc_packet_tx.sv - local-side NoC packet transmitter with header lock, inter-packet gap and ack timeout
// Define NOC_TX_PARITY_EN to drive even parity on packet[13]; otherwise that bit is 0.
module noc_packet_tx #(
   parameter int DEPTH   = 4,
   parameter int GAP     = 1,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        src_valid,
   output logic        src_ready,
   input  logic [1:0]  src_dst_addr,
   input  logic [1:0]  src_type,
   input  logic [7:0]  src_data,
   input  logic        src_last,
   output logic [13:0] packet,
   output logic        packet_valid,
   input  logic        ack,
   output logic        tx_busy,
   output logic        tx_timeout,
   output logic [7:0]  pkt_count
);

   import noc_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   tx_state_e     state_q, state_d;
   noc_flit_t     pkt_q, pkt_d;
   logic          valid_q, valid_d;
   logic [1:0]    hdr_dst_q, hdr_dst_d;
   noc_pkt_type_e hdr_type_q, hdr_type_d;
   logic          in_pkt_q, in_pkt_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          timeout_q, timeout_d;
   logic [7:0]    pkt_count_q, pkt_count_d;

   logic [PAR_BIT-1:0] fifo_rdata;
   logic [PAR_BIT-1:0] body;
   logic [AW:0]        fifo_count;
   logic               fifo_full, fifo_empty;
   logic               head_valid, push, load, acked, eop_acked, in_pkt_eff;

   assign src_ready  = !fifo_full;
   assign push       = src_valid && src_ready;
   assign head_valid = (fifo_count != '0);

   noc_sync_fifo #(
      .WIDTH (PAR_BIT),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({src_dst_addr, src_type, src_data, src_last}),
      .pop   (load),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      pkt_d       = pkt_q;
      valid_d     = valid_q;
      hdr_dst_d   = hdr_dst_q;
      hdr_type_d  = hdr_type_q;
      gap_cnt_d   = gap_cnt_q;
      to_cnt_d    = to_cnt_q;
      pkt_count_d = pkt_count_q;
      load        = 1'b0;

      acked     = valid_q && ack;
      eop_acked = acked && pkt_q.eop;
      // A flit loaded on the same edge an EOP is acked starts a fresh packet.
      in_pkt_eff = in_pkt_q && !eop_acked;
      in_pkt_d   = in_pkt_eff;

      if (eop_acked) begin
         pkt_count_d = pkt_count_q + 8'd1;
      end

      case (state_q)
         IDLE: begin
            if (head_valid) begin
               load = 1'b1;
            end
         end
         SEND: begin
            if (acked) begin
               if (pkt_q.eop && (GAP > 0)) begin
                  state_d   = noc_pkg::GAP;
                  valid_d   = 1'b0;
                  gap_cnt_d = '0;
               end else if (head_valid) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
               end
            end else if ((TIMEOUT > 0) && (to_cnt_q != TW'(TIMEOUT))) begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
         noc_pkg::GAP: begin
            if (gap_cnt_q == GW'(GAP - 1)) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase

      body = {in_pkt_eff ? hdr_dst_q : fifo_rdata[DST_MSB:DST_LSB],
              in_pkt_eff ? hdr_type_q : fifo_rdata[TYPE_MSB:TYPE_LSB],
              fifo_rdata[PAYLOAD_MSB:EOP_BIT]};

      if (load) begin
         state_d       = SEND;
         valid_d       = 1'b1;
         in_pkt_d      = 1'b1;
         to_cnt_d      = '0;
         pkt_d.dst     = body[DST_MSB:DST_LSB];
         pkt_d.ptype   = noc_pkt_type_e'(body[TYPE_MSB:TYPE_LSB]);
         pkt_d.payload = body[PAYLOAD_MSB:PAYLOAD_LSB];
         pkt_d.eop     = body[EOP_BIT];
`ifdef NOC_TX_PARITY_EN
         pkt_d.par     = flit_parity(body);
`else
         pkt_d.par     = 1'b0;
`endif
         hdr_dst_d     = body[DST_MSB:DST_LSB];
         hdr_type_d    = noc_pkt_type_e'(body[TYPE_MSB:TYPE_LSB]);
      end

      timeout_d = timeout_q || ((TIMEOUT > 0) && (to_cnt_d == TW'(TIMEOUT)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         pkt_q       <= '0;
         valid_q     <= 1'b0;
         hdr_dst_q   <= '0;
         hdr_type_q  <= REQ;
         in_pkt_q    <= 1'b0;
         gap_cnt_q   <= '0;
         to_cnt_q    <= '0;
         timeout_q   <= 1'b0;
         pkt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         pkt_q       <= pkt_d;
         valid_q     <= valid_d;
         hdr_dst_q   <= hdr_dst_d;
         hdr_type_q  <= hdr_type_d;
         in_pkt_q    <= in_pkt_d;
         gap_cnt_q   <= gap_cnt_d;
         to_cnt_q    <= to_cnt_d;
         timeout_q   <= timeout_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   assign packet       = pkt_q;
   assign packet_valid = valid_q;
   assign tx_busy      = (state_q != IDLE) || !fifo_empty;
   assign tx_timeout   = timeout_q;
   assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_noc_packet_tx.sv
// tb/tb_noc_packet_tx.sv - bench for noc_packet_tx: scoreboard model plus directed and random stimulus
module tb_noc_packet_tx;

   localparam int DEPTH   = 4;
   localparam int GAP     = 3;
   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        src_valid = 1'b0;
   logic        src_ready;
   logic [1:0]  src_dst_addr = '0;
   logic [1:0]  src_type = '0;
   logic [7:0]  src_data = '0;
   logic        src_last = 1'b0;
   logic [13:0] packet;
   logic        packet_valid;
   logic        ack = 1'b0;
   logic        tx_busy;
   logic        tx_timeout;
   logic [7:0]  pkt_count;

   int nerr = 0;
   int nchk = 0;

   noc_packet_tx #(
      .DEPTH   (DEPTH),
      .GAP     (GAP),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .src_valid    (src_valid),
      .src_ready    (src_ready),
      .src_dst_addr (src_dst_addr),
      .src_type     (src_type),
      .src_data     (src_data),
      .src_last     (src_last),
      .packet       (packet),
      .packet_valid (packet_valid),
      .ack          (ack),
      .tx_busy      (tx_busy),
      .tx_timeout   (tx_timeout),
      .pkt_count    (pkt_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: flits queued in push order with their expected packet word; a flit
   // loads once it has waited one edge and the link is free (prev ack, plus GAP+1 after EOP).
   typedef struct {
      logic [13:0] pkt;
      int          pe;
   } ent_t;

   ent_t        fq[$];
   logic [13:0] cur_pkt = '0;
   bit          cur_v = 0;
   int          ready_edge = 0;
   int          held = 0;
   bit          m_to = 0;
   logic [7:0]  m_cnt = '0;
   bit          s_in_pkt = 0;
   logic [1:0]  s_dst = '0;
   logic [1:0]  s_type = '0;
   int          cyc = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fq.delete();
         cur_v      = 0;
         ready_edge = 0;
         held       = 0;
         m_to       = 0;
         m_cnt      = '0;
         s_in_pkt   = 0;
      end else begin
         bit          rdy;
         logic [12:0] b;
         logic        par;
         cyc++;
         rdy = (fq.size() < DEPTH);
         if (cur_v) begin
            if (ack) begin
               cur_v = 0;
               if (cur_pkt[0]) begin
                  m_cnt++;
                  ready_edge = cyc + ((GAP > 0) ? GAP + 1 : 0);
               end else begin
                  ready_edge = cyc;
               end
            end else begin
               if (held < TIMEOUT) held++;
               if (TIMEOUT > 0 && held >= TIMEOUT) m_to = 1;
            end
         end
         if (!cur_v && fq.size() > 0 && fq[0].pe < cyc && ready_edge <= cyc) begin
            cur_pkt = fq[0].pkt;
            void'(fq.pop_front());
            cur_v = 1;
            held  = 0;
         end
         if (src_valid && rdy) begin
            if (!s_in_pkt) begin
               s_dst  = src_dst_addr;
               s_type = src_type;
            end
            b = {s_dst, s_type, src_data, src_last};
`ifdef NOC_TX_PARITY_EN
            par = ^b;
`else
            par = 1'b0;
`endif
            fq.push_back('{{par, b}, cyc});
            s_in_pkt = !src_last;
         end
      end
   end

   always @(negedge clk) begin
      chk("packet_valid", packet_valid, cur_v);
      if (cur_v) chk("packet", packet, cur_pkt);
      chk("src_ready", src_ready, fq.size() < DEPTH);
      chk("tx_busy", tx_busy, cur_v || fq.size() > 0 || (cyc < ready_edge - 1));
      chk("tx_timeout", tx_timeout, m_to);
      chk("pkt_count", pkt_count, m_cnt);
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_flit(input logic [1:0] d, input logic [1:0] t, input logic [7:0] dat, input logic l);
      src_valid    = 1'b1;
      src_dst_addr = d;
      src_type     = t;
      src_data     = dat;
      src_last     = l;
      @(posedge clk);
      #1;
      src_valid = 1'b0;
   endtask

   initial begin
      #200000;
      nerr++;
      $display("FAIL watchdog: got no completion expected finish by 200000");
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      logic [13:0] exp1;
      logic [13:0] held_pkt;
      int n, phase, low;
`ifdef NOC_TX_PARITY_EN
      exp1 = 14'h354B;
`else
      exp1 = 14'h154B;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_packet", packet, 14'h0);
      chk("rst_valid", packet_valid, 1'b0);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_timeout", tx_timeout, 1'b0);
      chk("rst_count", pkt_count, 8'd0);
      chk("rst_ready", src_ready, 1'b1);
      idle(1);

      // single flit, ack held high
      ack = 1'b1;
      drive_flit(2'd2, 2'd2, 8'hA5, 1'b1);
      @(negedge clk);
      chk("t1_not_yet", packet_valid, 1'b0);
      @(negedge clk);
      chk("t1_valid", packet_valid, 1'b1);
      chk("t1_packet", packet, exp1);
      @(negedge clk);
      chk("t1_count", pkt_count, 8'd1);
      idle(6);

      // header lock across a three-flit packet
      ack = 1'b0;
      drive_flit(2'd1, 2'd0, 8'h31, 1'b0);
      drive_flit(2'd3, 2'd3, 8'h32, 1'b0);
      drive_flit(2'd0, 2'd1, 8'h33, 1'b1);
      ack = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (packet_valid) begin
            chk("hdr_lock", packet[12:9], 4'b0100);
            n++;
         end
      end
      chk("hdr_lock_flits", n, 3);
      idle(2);

      // fill: one flit held plus a full FIFO
      ack = 1'b0;
      for (int i = 0; i < 5; i++) drive_flit(2'd1, 2'd2, 8'h10 + 8'(i), (i == 4));
      @(negedge clk);
      chk("full_ready", src_ready, 1'b0);
      chk("full_head", packet[8:1], 8'h10);
      @(posedge clk);
      #1 ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
      @(negedge clk);
      chk("full_ready_after", src_ready, 1'b1);
      chk("full_next", packet[8:1], 8'h11);
      @(posedge clk);
      #1 ack = 1'b1;
      idle(12);

      // gap between two single-flit packets
      drive_flit(2'd0, 2'd0, 8'h51, 1'b1);
      drive_flit(2'd3, 2'd1, 8'h52, 1'b1);
      phase = 0;
      low = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (phase == 0 && packet_valid) phase = 1;
         else if (phase == 1 && !packet_valid) begin
            phase = 2;
            low = 1;
         end else if (phase == 2) begin
            if (!packet_valid) low++;
            else phase = 3;
         end
      end
      chk("gap_low_cycles", low, 4);
      chk("gap_second_seen", phase, 3);
      idle(2);

      // ack timeout
      ack = 1'b0;
      drive_flit(2'd2, 2'd3, 8'h61, 1'b1);
      @(negedge clk);
      @(negedge clk);
      held_pkt = packet;
      repeat (7) @(negedge clk);
      chk("to_before", tx_timeout, 1'b0);
      @(negedge clk);
      chk("to_set", tx_timeout, 1'b1);
      chk("to_hold", packet, held_pkt);
      @(posedge clk);
      #1 ack = 1'b1;
      repeat (3) @(negedge clk);
      chk("to_sticky", tx_timeout, 1'b1);
      chk("to_drained", packet_valid, 1'b0);
      idle(8);

      // reset during the second flit of a three-flit packet
      ack = 1'b0;
      drive_flit(2'd3, 2'd3, 8'h41, 1'b0);
      drive_flit(2'd2, 2'd0, 8'h42, 1'b0);
      drive_flit(2'd1, 2'd1, 8'h43, 1'b1);
      ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
      chk("mid_second", packet[8:1], 8'h42);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_valid", packet_valid, 1'b0);
      chk("mid_rst_busy", tx_busy, 1'b0);
      chk("mid_rst_count", pkt_count, 8'd0);
      chk("mid_rst_ready", src_ready, 1'b1);
      chk("mid_rst_timeout", tx_timeout, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      ack = 1'b1;
      drive_flit(2'd0, 2'd1, 8'h77, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("fresh_valid", packet_valid, 1'b1);
      chk("fresh_hdr", packet[12:9], 4'b0001);
      idle(6);

      // randomized traffic and backpressure
      for (int i = 0; i < 500; i++) begin
         src_valid    = ($urandom_range(0, 1) == 1);
         src_dst_addr = 2'($urandom_range(0, 3));
         src_type     = 2'($urandom_range(0, 3));
         src_data     = 8'($urandom_range(0, 255));
         src_last     = ($urandom_range(0, 2) == 0);
         ack          = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      src_valid = 1'b0;
      ack = 1'b1;
      idle(40);
      @(negedge clk);
      chk("end_idle", tx_busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
